// File: rtl/shift_cmd_fifo.sv
// First-word-fall-through command FIFO feeding the barrel shifter's a/amt/lr inputs.
// The head entry is presented combinationally from storage; handshake flags derive from registered occupancy only.
module shift_cmd_fifo #(
  parameter int unsigned N         = 3,
  parameter int unsigned DEPTH_LOG = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [(2**N)-1:0]      in_a,
  input  logic [N-1:0]           in_amt,
  input  logic                   in_lr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [(2**N)-1:0]      a,
  output logic [N-1:0]           amt,
  output logic                   lr,
  output logic [DEPTH_LOG:0]     count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned W     = 2**N;
  localparam int unsigned DEPTH = 2**DEPTH_LOG;
  localparam int unsigned PW    = DEPTH_LOG;
  localparam int unsigned CW    = DEPTH_LOG + 1;

  typedef struct packed {
    logic [W-1:0] a;
    logic [N-1:0] amt;
    logic         lr;
  } cmd_t;

  cmd_t          mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push;
  logic          pop;
  cmd_t          head;
  cmd_t          in_cmd;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign count     = count_q;

  assign push   = in_valid && !full;
  assign pop    = !empty && out_ready;
  assign in_cmd = '{a: in_a, amt: in_amt, lr: in_lr};

  // Flush outranks any concurrent push or pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately left out of reset and flush.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= in_cmd;
  end

  assign head = mem_q[rd_ptr_q];
  assign a    = empty ? '0 : head.a;
  assign amt  = empty ? '0 : head.amt;
  assign lr   = empty ? 1'b0 : head.lr;

endmodule

// File: tb/tb_shift_cmd_fifo.sv
// Scoreboard bench for shift_cmd_fifo: a queue-based reference model tracks accepted commands,
// and a negedge monitor compares every visible output against it.
module tb_shift_cmd_fifo;

  localparam int unsigned DEPTH = 4;

  typedef struct packed {
    logic [7:0] a;
    logic [2:0] amt;
    logic       lr;
  } cmd_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [2:0] in_amt;
  logic       in_lr;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] a;
  logic [2:0] amt;
  logic       lr;
  logic [2:0] count;
  logic       full;
  logic       empty;

  int vectors = 0;
  int errors  = 0;

  cmd_t exp_q[$];

  shift_cmd_fifo dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_amt    (in_amt),
    .in_lr     (in_lr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .a         (a),
    .amt       (amt),
    .lr        (lr),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: a plain queue of accepted commands.
  always @(posedge clk or posedge reset) begin
    logic do_push;
    logic do_pop;
    if (reset || flush) begin
      exp_q.delete();
    end else begin
      do_pop  = (exp_q.size() > 0) && out_ready;
      do_push = in_valid && (exp_q.size() < DEPTH);
      if (do_pop)  void'(exp_q.pop_front());
      if (do_push) exp_q.push_back('{a: in_a, amt: in_amt, lr: in_lr});
    end
  end

  // Monitor: compare all outputs against the model away from the active edge.
  always @(negedge clk) begin
    int n;
    if (!reset) begin
      n = exp_q.size();
      check("count",     32'(count),     32'(n));
      check("full",      32'(full),      32'(n == DEPTH));
      check("empty",     32'(empty),     32'(n == 0));
      check("in_ready",  32'(in_ready),  32'(n < DEPTH));
      check("out_valid", 32'(out_valid), 32'(n > 0));
      check("head_a",    32'(a),   (n > 0) ? 32'(exp_q[0].a)   : 32'd0);
      check("head_amt",  32'(amt), (n > 0) ? 32'(exp_q[0].amt) : 32'd0);
      check("head_lr",   32'(lr),  (n > 0) ? 32'(exp_q[0].lr)  : 32'd0);
    end
  end

  task automatic drive(input logic v, input logic [7:0] da, input logic [2:0] damt,
                       input logic dlr, input logic ordy, input logic fl);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_a      = da;
    in_amt    = damt;
    in_lr     = dlr;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic idle(input logic ordy);
    drive(1'b0, 8'h00, 3'd0, 1'b0, ordy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_a = '0; in_amt = '0;
    in_lr = 1'b0; out_ready = 1'b0;
    #1;
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_count",     32'(count),     32'd0);
    check("rst_a",         32'(a),         32'd0);
    @(posedge clk); #1 reset = 1'b0;

    // Single command
    drive(1'b1, 8'hB4, 3'd3, 1'b1, 1'b0, 1'b0);
    idle(1'b0);
    @(negedge clk);
    check("single_a",     32'(a),     32'hB4);
    check("single_amt",   32'(amt),   32'd3);
    check("single_lr",    32'(lr),    32'd1);
    check("single_count", 32'(count), 32'd1);
    idle(1'b1);
    idle(1'b0);
    @(negedge clk);
    check("single_empty", 32'(empty), 32'd1);
    check("single_a0",    32'(a),     32'd0);

    // Fill to full, fifth command held off
    for (int i = 1; i <= 4; i++) drive(1'b1, 8'(i), 3'(i - 1), 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h05, 3'd4, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 8'h05, 3'd4, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("full_count", 32'(count),    32'd4);
    check("full_flag",  32'(full),     32'd1);
    check("full_ready", 32'(in_ready), 32'd0);
    check("full_head",  32'(a),        32'h01);
    // Pop while full with in_valid held: no push this edge
    drive(1'b1, 8'h05, 3'd4, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 8'h05, 3'd4, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("fullpop_count", 32'(count), 32'd3);
    check("fullpop_head",  32'(a),     32'h02);
    idle(1'b0);
    @(negedge clk);
    check("fullpop_accept", 32'(count), 32'd4);
    repeat (5) idle(1'b1);
    @(negedge clk);
    check("drain_empty", 32'(empty), 32'd1);

    // Simultaneous push/pop at count 2
    drive(1'b1, 8'h11, 3'd1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h12, 3'd2, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 8'h13, 3'd3, 1'b0, 1'b1, 1'b0);
    idle(1'b0);
    @(negedge clk);
    check("pp_count", 32'(count), 32'd2);
    check("pp_head",  32'(a),     32'h12);
    repeat (3) idle(1'b1);

    // Streaming across pointer wrap
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, 8'(i), 3'(i), i[0], 1'b1, 1'b0);
      @(negedge clk);
      check("wrap_count_le2", 32'(count <= 3'd2), 32'd1);
      if (i > 1) check("wrap_head", 32'(a), 32'(i - 1));
    end
    repeat (3) idle(1'b1);

    // Flush with concurrent push
    for (int i = 0; i < 3; i++) drive(1'b1, 8'(8'h21 + i), 3'(i), 1'b1, 1'b0, 1'b0);
    drive(1'b1, 8'h24, 3'd7, 1'b1, 1'b0, 1'b1);
    idle(1'b0);
    @(negedge clk);
    check("flush_count", 32'(count),     32'd0);
    check("flush_empty", 32'(empty),     32'd1);
    check("flush_valid", 32'(out_valid), 32'd0);
    repeat (2) idle(1'b0);

    // Async reset between edges with 3 queued
    for (int i = 0; i < 3; i++) drive(1'b1, 8'(8'h31 + i), 3'(i + 2), 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_count", 32'(count),     32'd0);
    check("arst_ready", 32'(in_ready),  32'd1);
    check("arst_a",     32'(a),         32'd0);
    check("arst_amt",   32'(amt),       32'd0);
    check("arst_lr",    32'(lr),        32'd0);
    @(posedge clk); #1 reset = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 8'($urandom), 3'($urandom), 1'($urandom),
            1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 24) == 0));
    end
    repeat (6) idle(1'b1);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
